simple_cpu: RTL and testbench



---
 rtl/simple_cpu_pkg.sv | 20 ++
 rtl/simple_cpu_ram.sv | 21 ++
 rtl/simple_cpu_regfile.sv | 23 ++
 rtl/simple_cpu.sv | 49 ++++
 tb/tb_simple_cpu.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: opcodes, instruction field positions and default widths shared by the CPU
package simple_cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_ORR  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hf;
  localparam int OP_LSB = 28;
  localparam int RD_LSB = 24;
  localparam int RN_LSB = 20;
  localparam int RM_LSB = 16;
  localparam int IMM_W  = 16;
endpackage

// File: rtl/simple_cpu_ram.sv
// simple_cpu_ram: unified instruction/data memory, async fetch and data reads, sync write, never cleared
module simple_cpu_ram
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] ddata,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] memory [2**ADDR_W];
  assign idata = memory[iaddr];
  assign ddata = memory[daddr];
  always_ff @(posedge clk)
    if (we) memory[daddr] <= wdata;
endmodule

// File: rtl/simple_cpu_regfile.sv
// simple_cpu_regfile: 16-entry register file, two async reads, one sync write, async clear
module simple_cpu_regfile
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [3:0]        ra_a,
  input  logic [3:0]        ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] registers [16];
  assign rd_a = registers[ra_a];
  assign rd_b = registers[ra_b];
  always_ff @(posedge clk or negedge rst)
    if (!rst) registers <= '{default: '0};
    else if (we) registers[wa] <= wd;
endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: single-cycle 32-bit load/store CPU with PC, halt flag, decode and ALU
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic rst
);
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [DATA_W-1:0] instr, a, b, imm, ea, ld, wd;
  logic [3:0]        op, rd, rn, rm;
  logic              reg_we, mem_we;
  assign op  = instr[OP_LSB +: 4];
  assign rd  = instr[RD_LSB +: 4];
  assign rn  = instr[RN_LSB +: 4];
  assign rm  = instr[RM_LSB +: 4];
  assign imm = DATA_W'(instr[IMM_W-1:0]);
  assign ea  = a + imm;
  // STR needs rd as its data source, which it never shares with rm
  simple_cpu_regfile #(.DATA_W(DATA_W)) register (
    .clk(clk), .rst(rst), .we(reg_we), .wa(rd), .wd(wd),
    .ra_a(rn), .ra_b(op == OP_STR ? rd : rm), .rd_a(a), .rd_b(b)
  );
  simple_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram (
    .clk(clk), .iaddr(pc), .idata(instr), .daddr(ea[ADDR_W-1:0]), .ddata(ld),
    .we(mem_we), .wdata(b)
  );
  always_comb begin
    wd = op == OP_MOVI ? imm :
         op == OP_ADD  ? a + b :
         op == OP_SUB  ? a - b :
         op == OP_AND  ? a & b :
         op == OP_ORR  ? a | b :
         op == OP_LDR  ? ld : ea;
    reg_we = !halted && (op inside {OP_MOVI, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDR, OP_ADDI});
    mem_we = rst && !halted && op == OP_STR;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (op == OP_HALT) halted <= 1'b1;
      else pc <= pc + ADDR_W'(1);
    end
endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: directed and random programs checked against an instruction-level model
module tb_simple_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] m_mem [256];
  logic [31:0] m_reg [16];
  int m_pc;
  bit m_halt;
  int nchk = 0;
  int nfail = 0;
  logic [31:0] p [$];

  simple_cpu dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(int op, int rd, int rn, int rm, int imm);
    return {op[3:0], rd[3:0], rn[3:0], rm[3:0], imm[15:0]};
  endfunction

  function automatic void mreset();
    m_pc = 0;
    m_halt = 0;
    foreach (m_reg[i]) m_reg[i] = '0;
  endfunction

  function automatic void mstep();
    logic [31:0] w, x, imm, ea;
    int rd, rn, rm;
    if (m_halt) return;
    w   = m_mem[m_pc];
    rd  = int'(w[27:24]);
    rn  = int'(w[23:20]);
    rm  = int'(w[19:16]);
    imm = {16'h0, w[15:0]};
    x   = m_reg[rn];
    ea  = x + imm;
    case (w[31:28])
      4'd1: m_reg[rd] = imm;
      4'd2: m_reg[rd] = x + m_reg[rm];
      4'd3: m_reg[rd] = x - m_reg[rm];
      4'd4: m_reg[rd] = x & m_reg[rm];
      4'd5: m_reg[rd] = x | m_reg[rm];
      4'd6: m_reg[rd] = m_mem[ea[7:0]];
      4'd7: m_mem[ea[7:0]] = m_reg[rd];
      4'd8: m_reg[rd] = ea;
      4'd15: m_halt = 1;
      default: ;
    endcase
    if (!m_halt) m_pc = (m_pc + 1) % 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, 32'(dut.pc), 32'(m_pc));
    for (int i = 0; i < 16; i++) chk($sformatf("%s.r%0d", tag, i), dut.register.registers[i], m_reg[i]);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 256; i++) chk($sformatf("%s.mem%0d", tag, i), dut.ram.memory[i], m_mem[i]);
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    dut.ram.memory[a] = v;
    m_mem[a] = v;
  endtask

  task automatic load(input bit rnd);
    rst = 1'b0;
    #1;
    mreset();
    for (int i = 0; i < 256; i++) poke(i, rnd ? 32'($urandom) : 32'h0);
    foreach (p[i]) poke(i, p[i]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    mstep();
    check_state(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    logic [31:0] hp;
    p = '{ins(1, 1, 0, 0, 5), ins(1, 2, 0, 0, 7), ins(2, 3, 1, 2, 0)};
    load(0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hold.pc", 32'(dut.pc), 32'h0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_hold.r%0d", i), dut.register.registers[i], 32'h0);
    foreach (p[i]) chk($sformatf("rst_hold.mem%0d", i), dut.ram.memory[i], p[i]);
    rst = 1'b1;
    run(3, "movi_add");
    chk("movi_add.r1", dut.register.registers[1], 32'd5);
    chk("movi_add.r2", dut.register.registers[2], 32'd7);
    chk("movi_add.r3", dut.register.registers[3], 32'd12);
    for (int i = 4; i < 16; i++) chk($sformatf("movi_add.r%0d", i), dut.register.registers[i], 32'h0);

    p = '{ins(1, 1, 0, 0, 16'h10), ins(6, 4, 1, 0, 16'h10)};
    load(0);
    poke(8'h20, 32'hDEADBEEF);
    rst = 1'b1;
    run(2, "ldr");
    chk("ldr.r4", dut.register.registers[4], 32'hDEADBEEF);

    p = '{ins(1, 2, 0, 0, 16'h1234), ins(7, 2, 0, 0, 16'h30), ins(6, 5, 0, 0, 16'h30)};
    load(0);
    rst = 1'b1;
    run(3, "str_ldr");
    chk("str_ldr.mem30", dut.ram.memory[8'h30], 32'h00001234);
    chk("str_ldr.r5", dut.register.registers[5], 32'h00001234);

    p = '{ins(6, 3, 0, 0, 16'h40), ins(1, 1, 0, 0, 0), ins(7, 3, 0, 0, 3), ins(1, 2, 0, 0, 16'h11)};
    load(0);
    poke(8'h40, ins(1, 2, 0, 0, 16'h55));
    rst = 1'b1;
    run(4, "selfmod");
    chk("selfmod.r2", dut.register.registers[2], 32'h55);

    p = '{ins(1, 1, 0, 0, 1), ins(3, 6, 0, 1, 0), ins(1, 7, 0, 0, 16'hFF), ins(8, 8, 7, 0, 16'h100),
          ins(7, 6, 7, 0, 16'h100), ins(6, 9, 7, 0, 16'h100), ins(15, 0, 0, 0, 0), ins(1, 10, 0, 0, 3)};
    load(0);
    rst = 1'b1;
    run(7, "wrap");
    chk("wrap.r6", dut.register.registers[6], 32'hFFFFFFFF);
    chk("wrap.r8", dut.register.registers[8], 32'h1FF);
    chk("wrap.memFF", dut.ram.memory[8'hFF], 32'hFFFFFFFF);
    chk("wrap.r9", dut.register.registers[9], 32'hFFFFFFFF);
    hp = 32'(dut.pc);
    for (int i = 0; i < 5; i++) begin
      tick("halt");
      chk("halt.pc_const", 32'(dut.pc), hp);
    end
    chk("halt.r10", dut.register.registers[10], 32'h0);

    p = '{};
    load(0);
    poke(255, ins(1, 1, 0, 0, 9));
    rst = 1'b1;
    run(256, "pcwrap");
    chk("pcwrap.pc", 32'(dut.pc), 32'h0);
    chk("pcwrap.r1", dut.register.registers[1], 32'd9);

    for (int r = 0; r < 4; r++) begin
      p = '{};
      for (int i = 0; i < 20; i++) begin
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 9, 12};
        p.push_back(ins(ops[$urandom_range(0, 11)], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 16'hFFFF))));
      end
      load(1);
      rst = 1'b1;
      run(12, "rand");
      if (r == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("midrst.pc", 32'(dut.pc), 32'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("midrst.r%0d", i), dut.register.registers[i], 32'h0);
        mreset();
        @(posedge clk);
        #1;
        check_state("midrst_hold");
        rst = 1'b1;
      end
      run(30, "rand");
      check_mem("rand");
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
